// File: rtl/xbar_master_interface.sv
// xbar_master_interface: slave-side crossbar port. Arbitrates AR/AW among the
// master interfaces, widens IDs with the source master number, orders W beats
// by AW grant order, and buffers R/B responses for the backward arbiters.

// Count-based FIFO; head is visible the cycle after a push (no bypass).
module xbar_mi_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout,
  output logic         full,
  output logic         empty
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wptr, rptr;
  logic [AW:0]   cnt;
  logic          do_push, do_pop;

  assign full    = (cnt == (AW+1)'(DEPTH));
  assign empty   = (cnt == '0);
  // a push while full is refused even if a pop frees a slot this cycle
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign dout    = mem[rptr];

  // pointer and occupancy bookkeeping; reset drops every stored entry
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr <= '0;
      rptr <= '0;
      cnt  <= '0;
    end else begin
      if (do_push) wptr <= wptr + 1'b1;
      if (do_pop)  rptr <= rptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
    end
  end

  // storage array, no reset needed since occupancy gates visibility
  always_ff @(posedge clk) begin
    if (do_push) mem[wptr] <= din;
  end
endmodule

// Round-robin arbiter for one address channel.
module xbar_mi_arb #(
  parameter int masters = 2,
  parameter int MW      = 1,
  parameter int SW      = 1,
  parameter int SLV     = 0
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          fifo_empty [0:masters-1],
  input  logic [SW-1:0] dest       [0:masters-1],
  input  logic          full,
  output logic [MW:0]   grant,
  output logic          push,
  output logic [MW-1:0] winner
);
  logic [MW-1:0]      rr_ptr;
  logic [masters-1:0] req;
  logic               found;

  // requests are masked while reset is asserted so no grant leaks out
  always_comb begin
    req = '0;
    for (int m = 0; m < masters; m++)
      req[m] = rst_n & ~fifo_empty[m] & (dest[m] == SW'(SLV));
  end

  // first requester at or after rr_ptr, wrapping
  always_comb begin
    int idx;
    idx    = 0;
    found  = 1'b0;
    winner = '0;
    for (int i = 0; i < masters; i++) begin
      idx = (int'(rr_ptr) + i) % masters;
      if (!found && req[idx]) begin
        found  = 1'b1;
        winner = MW'(idx);
      end
    end
  end

  assign push  = found & ~full;
  assign grant = found ? {1'b0, winner} : {1'b1, {MW{1'b0}}};

  // pointer moves past the winner only when the request is accepted
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)    rr_ptr <= '0;
    else if (push) rr_ptr <= MW'((int'(winner) + 1) % masters);
  end
endmodule

module xbar_master_interface #(
  parameter int ID_WIDTH          = 4,
  parameter int IDS_WIDTH         = 8,
  parameter int ADDR_WIDTH        = 32,
  parameter int LEN_WIDTH         = 4,
  parameter int SIZE_WIDTH        = 3,
  parameter int DATA_WIDTH        = 32,
  parameter int STRB_WIDTH        = 4,
  parameter int pending_depth     = 8,
  parameter int masters           = 2,
  parameter int slaves            = 2,
  parameter int i_am_slave_number = 0,
  localparam int MW = (masters > 1) ? $clog2(masters) : 1,
  localparam int SW = (slaves  > 1) ? $clog2(slaves)  : 1
) (
  input  logic                  ACLK,
  input  logic                  ARESETn,
  // AR fabric side
  input  logic [ID_WIDTH-1:0]   ARID    [0:masters-1],
  input  logic [ADDR_WIDTH-1:0] ARADDR  [0:masters-1],
  input  logic [LEN_WIDTH-1:0]  ARLEN   [0:masters-1],
  input  logic [SIZE_WIDTH-1:0] ARSIZE  [0:masters-1],
  input  logic [1:0]            ARBURST [0:masters-1],
  input  logic                  master_read_addr_fifo_empty  [0:masters-1],
  input  logic [SW-1:0]         read_addr_forward_dest_slave [0:masters-1],
  output logic [MW:0]           slave_grant_read_addr_master_number,
  output logic                  slave_read_addr_push_to_fifo,
  output logic                  slave_read_addr_fifo_full,
  // AW fabric side
  input  logic [ID_WIDTH-1:0]   AWID    [0:masters-1],
  input  logic [ADDR_WIDTH-1:0] AWADDR  [0:masters-1],
  input  logic [LEN_WIDTH-1:0]  AWLEN   [0:masters-1],
  input  logic [SIZE_WIDTH-1:0] AWSIZE  [0:masters-1],
  input  logic [1:0]            AWBURST [0:masters-1],
  input  logic                  master_write_addr_fifo_empty  [0:masters-1],
  input  logic [SW-1:0]         write_addr_forward_dest_slave [0:masters-1],
  output logic [MW:0]           slave_grant_write_addr_master_number,
  output logic                  slave_write_addr_push_to_fifo,
  output logic                  slave_write_addr_fifo_full,
  // W fabric side
  input  logic [DATA_WIDTH-1:0] WDATA [0:masters-1],
  input  logic [STRB_WIDTH-1:0] WSTRB [0:masters-1],
  input  logic                  WLAST [0:masters-1],
  input  logic                  master_write_data_fifo_empty  [0:masters-1],
  input  logic [SW-1:0]         write_data_forward_dest_slave [0:masters-1],
  output logic                  slave_write_data_fifo_full    [0:masters-1],
  // R fabric side
  output logic [ID_WIDTH-1:0]   RID,
  output logic [DATA_WIDTH-1:0] RDATA,
  output logic [1:0]            RRESP,
  output logic                  RLAST,
  output logic [MW-1:0]         read_data_return_dest_master,
  output logic                  slave_read_data_fifo_empty,
  input  logic                  read_data_pop,
  // B fabric side
  output logic [ID_WIDTH-1:0]   BID,
  output logic [1:0]            BRESP,
  output logic [MW-1:0]         write_resp_return_dest_master,
  output logic                  slave_write_resp_fifo_empty,
  input  logic                  write_resp_pop,
  // outer slave AR
  output logic [IDS_WIDTH-1:0]  ARID_S,
  output logic [ADDR_WIDTH-1:0] ARADDR_S,
  output logic [LEN_WIDTH-1:0]  ARLEN_S,
  output logic [SIZE_WIDTH-1:0] ARSIZE_S,
  output logic [1:0]            ARBURST_S,
  output logic                  ARVALID_S,
  input  logic                  ARREADY_S,
  // outer slave AW
  output logic [IDS_WIDTH-1:0]  AWID_S,
  output logic [ADDR_WIDTH-1:0] AWADDR_S,
  output logic [LEN_WIDTH-1:0]  AWLEN_S,
  output logic [SIZE_WIDTH-1:0] AWSIZE_S,
  output logic [1:0]            AWBURST_S,
  output logic                  AWVALID_S,
  input  logic                  AWREADY_S,
  // outer slave W
  output logic [DATA_WIDTH-1:0] WDATA_S,
  output logic [STRB_WIDTH-1:0] WSTRB_S,
  output logic                  WLAST_S,
  output logic                  WVALID_S,
  input  logic                  WREADY_S,
  // outer slave R
  input  logic [IDS_WIDTH-1:0]  RID_S,
  input  logic [DATA_WIDTH-1:0] RDATA_S,
  input  logic [1:0]            RRESP_S,
  input  logic                  RLAST_S,
  input  logic                  RVALID_S,
  output logic                  RREADY_S,
  // outer slave B
  input  logic [IDS_WIDTH-1:0]  BID_S,
  input  logic [1:0]            BRESP_S,
  input  logic                  BVALID_S,
  output logic                  BREADY_S
);
  localparam logic [SW-1:0] SLV = SW'(i_am_slave_number);
  localparam int AXW = IDS_WIDTH + ADDR_WIDTH + LEN_WIDTH + SIZE_WIDTH + 2;
  localparam int WW  = DATA_WIDTH + STRB_WIDTH + 1;
  localparam int RTW = ID_WIDTH + MW;             // ID bits kept for return routing
  localparam int RW  = RTW + DATA_WIDTH + 2 + 1;
  localparam int BW  = RTW + 2;

  // ---------------- AR ----------------
  logic [MW-1:0]        ar_win;
  logic [IDS_WIDTH-1:0] ar_ids;
  logic [AXW-1:0]       ar_dout;
  logic                 ar_empty;

  xbar_mi_arb #(.masters(masters), .MW(MW), .SW(SW), .SLV(i_am_slave_number)) u_ar_arb (
    .clk(ACLK), .rst_n(ARESETn),
    .fifo_empty(master_read_addr_fifo_empty), .dest(read_addr_forward_dest_slave),
    .full(slave_read_addr_fifo_full),
    .grant(slave_grant_read_addr_master_number),
    .push(slave_read_addr_push_to_fifo), .winner(ar_win));

  // widened ID: source master number sits just above the master-side ID
  always_comb begin
    ar_ids = '0;
    ar_ids[ID_WIDTH-1:0]  = ARID[ar_win];
    ar_ids[ID_WIDTH +: MW] = ar_win;
  end

  xbar_mi_fifo #(.W(AXW), .DEPTH(pending_depth)) u_ar_fifo (
    .clk(ACLK), .rst_n(ARESETn),
    .push(slave_read_addr_push_to_fifo), .pop(ARVALID_S & ARREADY_S),
    .din({ar_ids, ARADDR[ar_win], ARLEN[ar_win], ARSIZE[ar_win], ARBURST[ar_win]}),
    .dout(ar_dout), .full(slave_read_addr_fifo_full), .empty(ar_empty));

  assign {ARID_S, ARADDR_S, ARLEN_S, ARSIZE_S, ARBURST_S} = ar_dout;
  assign ARVALID_S = ~ar_empty;

  // ---------------- AW + W order ----------------
  logic [MW-1:0]        aw_win;
  logic [IDS_WIDTH-1:0] aw_ids;
  logic [AXW-1:0]       aw_dout;
  logic                 aw_empty, aw_full;
  logic [MW-1:0]        wq_head;
  logic                 wq_empty, wq_full;

  // AW can only be taken while the W-order queue also has room
  assign slave_write_addr_fifo_full = aw_full | wq_full;

  xbar_mi_arb #(.masters(masters), .MW(MW), .SW(SW), .SLV(i_am_slave_number)) u_aw_arb (
    .clk(ACLK), .rst_n(ARESETn),
    .fifo_empty(master_write_addr_fifo_empty), .dest(write_addr_forward_dest_slave),
    .full(slave_write_addr_fifo_full),
    .grant(slave_grant_write_addr_master_number),
    .push(slave_write_addr_push_to_fifo), .winner(aw_win));

  // widened write ID, same layout as the read side
  always_comb begin
    aw_ids = '0;
    aw_ids[ID_WIDTH-1:0]  = AWID[aw_win];
    aw_ids[ID_WIDTH +: MW] = aw_win;
  end

  xbar_mi_fifo #(.W(AXW), .DEPTH(pending_depth)) u_aw_fifo (
    .clk(ACLK), .rst_n(ARESETn),
    .push(slave_write_addr_push_to_fifo), .pop(AWVALID_S & AWREADY_S),
    .din({aw_ids, AWADDR[aw_win], AWLEN[aw_win], AWSIZE[aw_win], AWBURST[aw_win]}),
    .dout(aw_dout), .full(aw_full), .empty(aw_empty));

  assign {AWID_S, AWADDR_S, AWLEN_S, AWSIZE_S, AWBURST_S} = aw_dout;
  assign AWVALID_S = ~aw_empty;

  logic [WW-1:0] w_dout;
  logic          w_full, w_empty, w_accept;

  // head master's beat is taken only if it is really addressed here
  assign w_accept = ~wq_empty & ~w_full & ~master_write_data_fifo_empty[wq_head]
                  & (write_data_forward_dest_slave[wq_head] == SLV);

  xbar_mi_fifo #(.W(MW), .DEPTH(pending_depth)) u_wq_fifo (
    .clk(ACLK), .rst_n(ARESETn),
    .push(slave_write_addr_push_to_fifo), .pop(w_accept & WLAST[wq_head]),
    .din(aw_win), .dout(wq_head), .full(wq_full), .empty(wq_empty));

  for (genvar m = 0; m < masters; m++) begin : g_wfull
    assign slave_write_data_fifo_full[m] = ~(~wq_empty & (wq_head == MW'(m)) & ~w_full);
  end

  xbar_mi_fifo #(.W(WW), .DEPTH(pending_depth)) u_w_fifo (
    .clk(ACLK), .rst_n(ARESETn),
    .push(w_accept), .pop(WVALID_S & WREADY_S),
    .din({WDATA[wq_head], WSTRB[wq_head], WLAST[wq_head]}),
    .dout(w_dout), .full(w_full), .empty(w_empty));

  assign {WDATA_S, WSTRB_S, WLAST_S} = w_dout;
  assign WVALID_S = ~w_empty;

  // ---------------- R ----------------
  logic [RW-1:0]  r_dout;
  logic [RTW-1:0] r_tag;
  logic           r_full;

  assign RREADY_S = ~r_full;

  xbar_mi_fifo #(.W(RW), .DEPTH(pending_depth)) u_r_fifo (
    .clk(ACLK), .rst_n(ARESETn),
    .push(RVALID_S & RREADY_S), .pop(read_data_pop),
    .din({RID_S[RTW-1:0], RDATA_S, RRESP_S, RLAST_S}),
    .dout(r_dout), .full(r_full), .empty(slave_read_data_fifo_empty));

  assign {r_tag, RDATA, RRESP, RLAST} = r_dout;
  assign RID = r_tag[ID_WIDTH-1:0];
  assign read_data_return_dest_master = r_tag[ID_WIDTH +: MW];

  // ---------------- B ----------------
  logic [BW-1:0]  b_dout;
  logic [RTW-1:0] b_tag;
  logic           b_full;

  assign BREADY_S = ~b_full;

  xbar_mi_fifo #(.W(BW), .DEPTH(pending_depth)) u_b_fifo (
    .clk(ACLK), .rst_n(ARESETn),
    .push(BVALID_S & BREADY_S), .pop(write_resp_pop),
    .din({BID_S[RTW-1:0], BRESP_S}),
    .dout(b_dout), .full(b_full), .empty(slave_write_resp_fifo_empty));

  assign {b_tag, BRESP} = b_dout;
  assign BID = b_tag[ID_WIDTH-1:0];
  assign write_resp_return_dest_master = b_tag[ID_WIDTH +: MW];
endmodule

// File: tb/tb_xbar_master_interface.sv
// Directed bench for xbar_master_interface with hand-computed expectations.
module tb_xbar_master_interface;
  localparam int M = 2;

  logic ACLK, ARESETn;
  logic [3:0]  ARID [0:M-1];
  logic [31:0] ARADDR [0:M-1];
  logic [3:0]  ARLEN [0:M-1];
  logic [2:0]  ARSIZE [0:M-1];
  logic [1:0]  ARBURST [0:M-1];
  logic        ar_e [0:M-1];
  logic [0:0]  ar_d [0:M-1];
  logic [1:0]  ar_grant;
  logic        ar_push, ar_full;
  logic [3:0]  AWID [0:M-1];
  logic [31:0] AWADDR [0:M-1];
  logic [3:0]  AWLEN [0:M-1];
  logic [2:0]  AWSIZE [0:M-1];
  logic [1:0]  AWBURST [0:M-1];
  logic        aw_e [0:M-1];
  logic [0:0]  aw_d [0:M-1];
  logic [1:0]  aw_grant;
  logic        aw_push, aw_full;
  logic [31:0] WDATA [0:M-1];
  logic [3:0]  WSTRB [0:M-1];
  logic        WLAST [0:M-1];
  logic        w_e [0:M-1];
  logic [0:0]  w_d [0:M-1];
  logic        wfull [0:M-1];
  logic [3:0]  RID, BID;
  logic [31:0] RDATA;
  logic [1:0]  RRESP, BRESP;
  logic        RLAST;
  logic [0:0]  r_dest, b_dest;
  logic        r_empty, b_empty, read_data_pop, write_resp_pop;
  logic [7:0]  ARID_S, AWID_S, RID_S, BID_S;
  logic [31:0] ARADDR_S, AWADDR_S, WDATA_S, RDATA_S;
  logic [3:0]  ARLEN_S, AWLEN_S, WSTRB_S;
  logic [2:0]  ARSIZE_S, AWSIZE_S;
  logic [1:0]  ARBURST_S, AWBURST_S, RRESP_S, BRESP_S;
  logic        ARVALID_S, ARREADY_S, AWVALID_S, AWREADY_S, WLAST_S, WVALID_S, WREADY_S;
  logic        RLAST_S, RVALID_S, RREADY_S, BVALID_S, BREADY_S;

  int n_asserts = 0;
  int n_fail    = 0;

  xbar_master_interface dut (
    .ACLK(ACLK), .ARESETn(ARESETn),
    .ARID(ARID), .ARADDR(ARADDR), .ARLEN(ARLEN), .ARSIZE(ARSIZE), .ARBURST(ARBURST),
    .master_read_addr_fifo_empty(ar_e), .read_addr_forward_dest_slave(ar_d),
    .slave_grant_read_addr_master_number(ar_grant), .slave_read_addr_push_to_fifo(ar_push),
    .slave_read_addr_fifo_full(ar_full),
    .AWID(AWID), .AWADDR(AWADDR), .AWLEN(AWLEN), .AWSIZE(AWSIZE), .AWBURST(AWBURST),
    .master_write_addr_fifo_empty(aw_e), .write_addr_forward_dest_slave(aw_d),
    .slave_grant_write_addr_master_number(aw_grant), .slave_write_addr_push_to_fifo(aw_push),
    .slave_write_addr_fifo_full(aw_full),
    .WDATA(WDATA), .WSTRB(WSTRB), .WLAST(WLAST),
    .master_write_data_fifo_empty(w_e), .write_data_forward_dest_slave(w_d),
    .slave_write_data_fifo_full(wfull),
    .RID(RID), .RDATA(RDATA), .RRESP(RRESP), .RLAST(RLAST),
    .read_data_return_dest_master(r_dest), .slave_read_data_fifo_empty(r_empty),
    .read_data_pop(read_data_pop),
    .BID(BID), .BRESP(BRESP), .write_resp_return_dest_master(b_dest),
    .slave_write_resp_fifo_empty(b_empty), .write_resp_pop(write_resp_pop),
    .ARID_S(ARID_S), .ARADDR_S(ARADDR_S), .ARLEN_S(ARLEN_S), .ARSIZE_S(ARSIZE_S),
    .ARBURST_S(ARBURST_S), .ARVALID_S(ARVALID_S), .ARREADY_S(ARREADY_S),
    .AWID_S(AWID_S), .AWADDR_S(AWADDR_S), .AWLEN_S(AWLEN_S), .AWSIZE_S(AWSIZE_S),
    .AWBURST_S(AWBURST_S), .AWVALID_S(AWVALID_S), .AWREADY_S(AWREADY_S),
    .WDATA_S(WDATA_S), .WSTRB_S(WSTRB_S), .WLAST_S(WLAST_S), .WVALID_S(WVALID_S),
    .WREADY_S(WREADY_S),
    .RID_S(RID_S), .RDATA_S(RDATA_S), .RRESP_S(RRESP_S), .RLAST_S(RLAST_S),
    .RVALID_S(RVALID_S), .RREADY_S(RREADY_S),
    .BID_S(BID_S), .BRESP_S(BRESP_S), .BVALID_S(BVALID_S), .BREADY_S(BREADY_S));

  initial ACLK = 1'b0;
  always #5 ACLK = ~ACLK;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_asserts++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge ACLK);
    #1;
  endtask

  int exp_g [5] = '{1, 0, 1, 0, 1};

  initial begin
    ARESETn = 1'b0;
    for (int m = 0; m < M; m++) begin
      ARID[m] = '0; ARADDR[m] = '0; ARLEN[m] = '0; ARSIZE[m] = 3'd2; ARBURST[m] = 2'd1;
      AWID[m] = '0; AWADDR[m] = '0; AWLEN[m] = '0; AWSIZE[m] = 3'd2; AWBURST[m] = 2'd1;
      WDATA[m] = '0; WSTRB[m] = 4'hF; WLAST[m] = 1'b0;
      ar_e[m] = 1'b1; aw_e[m] = 1'b1; w_e[m] = 1'b1;
      ar_d[m] = 1'b0; aw_d[m] = 1'b0; w_d[m] = 1'b0;
    end
    read_data_pop = 0; write_resp_pop = 0;
    ARREADY_S = 0; AWREADY_S = 0; WREADY_S = 0;
    RID_S = '0; RDATA_S = '0; RRESP_S = '0; RLAST_S = 0; RVALID_S = 0;
    BID_S = '0; BRESP_S = '0; BVALID_S = 0;
    ar_e[0] = 1'b0;   // a request during reset must not be granted

    // reset state
    #3;
    chk("rst_arvalid", ARVALID_S, 0);
    chk("rst_rready", RREADY_S, 1);
    chk("rst_bready", BREADY_S, 1);
    chk("rst_ar_full", ar_full, 0);
    chk("rst_aw_full", aw_full, 0);
    chk("rst_ar_grant", ar_grant, 2'b10);
    chk("rst_ar_push", ar_push, 0);
    chk("rst_wfull0", wfull[0], 1);
    chk("rst_wfull1", wfull[1], 1);
    chk("rst_r_empty", r_empty, 1);
    chk("rst_b_empty", b_empty, 1);
    ar_e[0] = 1'b1;
    step(); step();
    ARESETn = 1'b1;

    // single read
    ar_e[0] = 0; ARID[0] = 4'd3; ARADDR[0] = 32'h40;
    #1;
    chk("rd_grant", ar_grant, 0);
    chk("rd_push", ar_push, 1);
    step();
    ar_e[0] = 1;
    #1;
    chk("rd_arvalid", ARVALID_S, 1);
    chk("rd_arid_s", ARID_S, 8'h03);
    chk("rd_araddr_s", ARADDR_S, 32'h40);
    ARREADY_S = 1;
    step();
    ARREADY_S = 0;
    #1;
    chk("rd_arvalid_pop", ARVALID_S, 0);
    RVALID_S = 1; RID_S = 8'h03; RDATA_S = 32'hDEADBEEF; RLAST_S = 1;
    #1;
    chk("rd_rready", RREADY_S, 1);
    step();
    RVALID_S = 0;
    #1;
    chk("rd_rid", RID, 3);
    chk("rd_rdata", RDATA, 32'hDEADBEEF);
    chk("rd_rlast", RLAST, 1);
    chk("rd_rdest", r_dest, 0);
    chk("rd_r_empty", r_empty, 0);
    read_data_pop = 1;
    step();
    read_data_pop = 0;
    #1;
    chk("rd_r_empty_pop", r_empty, 1);

    // write response with ID from master 1
    BVALID_S = 1; BID_S = 8'h17; BRESP_S = 2'd2;
    step();
    BVALID_S = 0;
    #1;
    chk("b_bid", BID, 7);
    chk("b_bresp", BRESP, 2);
    chk("b_dest", b_dest, 1);
    chk("b_empty", b_empty, 0);
    write_resp_pop = 1;
    step();
    write_resp_pop = 0;
    #1;
    chk("b_empty_pop", b_empty, 1);

    // request aimed at another slave is ignored
    ar_d[1] = 1; ar_e[1] = 0;
    #1;
    chk("dest_miss_grant", ar_grant, 2'b10);
    chk("dest_miss_push", ar_push, 0);
    ar_d[1] = 0;

    // contention: lone master 1 first (rr_ptr back to 0), then alternation
    ARID[0] = 4'd2; ARID[1] = 4'd5; ARREADY_S = 1;
    for (int k = 0; k < 5; k++) begin
      ar_e[0] = (k == 0);
      ar_e[1] = 0;
      #1;
      chk($sformatf("rr_grant%0d", k), ar_grant, exp_g[k]);
      chk($sformatf("rr_push%0d", k), ar_push, 1);
      if (k > 0) chk($sformatf("rr_arid_s%0d", k), ARID_S, (exp_g[k-1] == 1) ? 8'h15 : 8'h02);
      step();
    end
    ar_e[0] = 1; ar_e[1] = 1;
    #1;
    chk("rr_arid_last", ARID_S, 8'h15);
    step();
    ARREADY_S = 0;
    #1;
    chk("rr_drained", ARVALID_S, 0);

    // write ordering
    aw_e[1] = 0; AWID[1] = 4'd1; AWLEN[1] = 4'd1; AWADDR[1] = 32'h100;
    #1;
    chk("aw_grant1", aw_grant, 1);
    chk("aw_push1", aw_push, 1);
    step();
    aw_e[1] = 1; aw_e[0] = 0; AWID[0] = 4'd2; AWLEN[0] = 4'd0;
    #1;
    chk("aw_grant0", aw_grant, 0);
    chk("aw_push0", aw_push, 1);
    step();
    aw_e[0] = 1;
    #1;
    chk("wo_full1", wfull[1], 0);
    chk("wo_full0", wfull[0], 1);
    chk("aw_awvalid", AWVALID_S, 1);
    chk("aw_awid_s", AWID_S, 8'h11);
    chk("aw_awlen_s", AWLEN_S, 1);
    w_e[0] = 0; WDATA[0] = 32'hB0; WLAST[0] = 1;
    #1;
    chk("wo_m0_blocked", wfull[0], 1);
    step();
    chk("wo_no_beat", WVALID_S, 0);
    w_e[1] = 0; WDATA[1] = 32'hA1; WLAST[1] = 0;
    step();
    WDATA[1] = 32'hA2; WLAST[1] = 1;
    #1;
    chk("wo_full1_b2", wfull[1], 0);
    chk("wo_full0_b2", wfull[0], 1);
    step();
    w_e[1] = 1;
    #1;
    chk("wo_full0_open", wfull[0], 0);
    chk("wo_full1_done", wfull[1], 1);
    step();
    w_e[0] = 1;
    #1;
    chk("wo_q_empty0", wfull[0], 1);
    chk("wo_q_empty1", wfull[1], 1);
    chk("w_valid", WVALID_S, 1);
    chk("w_beat0", WDATA_S, 32'hA1);
    chk("w_last0", WLAST_S, 0);
    WREADY_S = 1; AWREADY_S = 1;
    step();
    chk("w_beat1", WDATA_S, 32'hA2);
    chk("w_last1", WLAST_S, 1);
    step();
    chk("w_beat2", WDATA_S, 32'hB0);
    chk("w_last2", WLAST_S, 1);
    step();
    WREADY_S = 0; AWREADY_S = 0;
    #1;
    chk("w_drained", WVALID_S, 0);
    chk("aw_drained", AWVALID_S, 0);

    // AR buffer full boundary
    ar_e[0] = 0;
    for (int k = 0; k < 8; k++) begin
      ARID[0] = 4'(k);
      #1;
      chk($sformatf("fill_push%0d", k), ar_push, 1);
      chk($sformatf("fill_full%0d", k), ar_full, 0);
      step();
    end
    chk("full_set", ar_full, 1);
    chk("full_push", ar_push, 0);
    chk("full_grant", ar_grant, 0);
    step();
    chk("full_stall", ar_full, 1);
    chk("full_head", ARID_S, 8'h00);
    ARREADY_S = 1;
    #1;
    chk("full_pop_push", ar_push, 0);
    step();
    ARREADY_S = 0;
    #1;
    chk("full_drop", ar_full, 0);
    chk("full_head2", ARID_S, 8'h01);
    chk("full_push_again", ar_push, 1);
    ar_e[0] = 1;

    // R buffer fill, then pop-with-push keeps the count
    RVALID_S = 1; RLAST_S = 0; RRESP_S = 0;
    for (int k = 0; k < 8; k++) begin
      RID_S = 8'(8'h18 + k); RDATA_S = 32'(k);
      #1;
      chk($sformatf("rfill_rready%0d", k), RREADY_S, 1);
      step();
    end
    chk("rfull_rready", RREADY_S, 0);
    chk("rfull_rid", RID, 8);
    chk("rfull_dest", r_dest, 1);
    read_data_pop = 1; RID_S = 8'h13; RDATA_S = 32'h33;
    step();
    chk("rpop_rready", RREADY_S, 1);
    chk("rpop_rid", RID, 9);
    step();
    read_data_pop = 0; RVALID_S = 0;
    #1;
    chk("rboth_rready", RREADY_S, 1);
    chk("rboth_rid", RID, 10);
    read_data_pop = 1;
    for (int k = 0; k < 6; k++) step();
    chk("rdrain_rid", RID, 3);
    chk("rdrain_data", RDATA, 32'h33);
    chk("rdrain_notempty", r_empty, 0);
    step();
    read_data_pop = 0;
    #1;
    chk("rdrain_empty", r_empty, 1);

    // async reset with entries buffered
    RVALID_S = 1; RID_S = 8'h01;
    step();
    RVALID_S = 0;
    #1;
    chk("pre_rst_arvalid", ARVALID_S, 1);
    chk("pre_rst_r_empty", r_empty, 0);
    ARESETn = 0;
    #1;
    chk("mid_rst_arvalid", ARVALID_S, 0);
    chk("mid_rst_r_empty", r_empty, 1);
    chk("mid_rst_rready", RREADY_S, 1);
    chk("mid_rst_wfull0", wfull[0], 1);
    step();
    ARESETn = 1;
    ar_e[0] = 0; ar_e[1] = 0; ARID[0] = 4'd6; ARID[1] = 4'd4;
    #1;
    chk("post_rst_grant", ar_grant, 0);
    chk("post_rst_push", ar_push, 1);
    step();
    ar_e[0] = 1; ar_e[1] = 1;
    #1;
    chk("post_rst_arvalid", ARVALID_S, 1);
    chk("post_rst_arid_s", ARID_S, 8'h06);

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end
endmodule
